// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multicycle RV32I core. It sequences fetch, decode,
// execute, memory and writeback, and it drives the alu_op field and the datapath selects and strobes.
module multicycle_control_fsm #(
  parameter int INSTRET_WIDTH   = 32,
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [6:0]               opcode,
  input  logic                     mem_ready,
  output logic [1:0]               alu_op,
  output logic [1:0]               alu_src_a,
  output logic [1:0]               alu_src_b,
  output logic [1:0]               result_src,
  output logic                     adr_src,
  output logic                     ir_write,
  output logic                     pc_update,
  output logic                     branch,
  output logic                     reg_write,
  output logic                     mem_we,
  output logic                     halted,
  output logic [INSTRET_WIDTH-1:0] instret
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXEC_R, S_EXEC_I, S_LUI, S_AUIPC, S_ALUWB, S_BRANCH,
    S_JAL, S_JALR, S_JALR_LINK, S_TRAP
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [INSTRET_WIDTH-1:0] RET_ONE = {{(INSTRET_WIDTH-1){1'b0}}, 1'b1};

  state_t state, state_nxt;
  logic   retire;
  logic   ir_write_raw, pc_update_raw, branch_raw, reg_write_raw, mem_we_raw;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= S_FETCH;
      instret <= '0;
    end else begin
      state <= state_nxt;
      if (retire) instret <= instret + RET_ONE;
    end
  end

  always_comb begin
    state_nxt     = state;
    retire        = 1'b0;
    alu_op        = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    result_src    = 2'b00;
    adr_src       = 1'b0;
    ir_write_raw  = 1'b0;
    pc_update_raw = 1'b0;
    branch_raw    = 1'b0;
    reg_write_raw = 1'b0;
    mem_we_raw    = 1'b0;
    halted        = 1'b0;
    case (state)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (mem_ready) begin
          ir_write_raw  = 1'b1;
          pc_update_raw = 1'b1;
          state_nxt     = S_DECODE;
        end
      end
      S_DECODE: begin
        // Precompute old PC + imm so branch/JAL targets sit in ALUOut
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (opcode)
          OP_R:              state_nxt = S_EXEC_R;
          OP_I:              state_nxt = S_EXEC_I;
          OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
          OP_BR:             state_nxt = S_BRANCH;
          OP_JAL:            state_nxt = S_JAL;
          OP_JALR:           state_nxt = S_JALR;
          OP_LUI:            state_nxt = S_LUI;
          OP_AUIPC:          state_nxt = S_AUIPC;
          default: begin
            if (TRAP_ON_ILLEGAL) begin
              state_nxt = S_TRAP;
            end else begin
              state_nxt = S_FETCH;
              retire    = 1'b1;
            end
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        // Loads and stores differ only in opcode bit 5
        state_nxt = opcode[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (mem_ready) state_nxt = S_MEMWB;
      end
      S_MEMWB: begin
        result_src    = 2'b01;
        reg_write_raw = 1'b1;
        retire        = 1'b1;
        state_nxt     = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src    = 1'b1;
        mem_we_raw = 1'b1;
        if (mem_ready) begin
          retire    = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_EXEC_R: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_nxt = S_ALUWB;
      end
      S_EXEC_I, S_LUI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_nxt = S_ALUWB;
      end
      S_AUIPC: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        state_nxt = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_raw = 1'b1;
        retire        = 1'b1;
        state_nxt     = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 2'b10;
        alu_op     = 2'b01;
        branch_raw = 1'b1;
        retire     = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_JAL: begin
        // Jump to ALUOut target while the ALU forms the link value old PC + 4
        alu_src_a     = 2'b01;
        alu_src_b     = 2'b10;
        pc_update_raw = 1'b1;
        state_nxt     = S_ALUWB;
      end
      S_JALR: begin
        alu_src_a     = 2'b10;
        alu_src_b     = 2'b01;
        result_src    = 2'b10;
        pc_update_raw = 1'b1;
        state_nxt     = S_JALR_LINK;
      end
      S_JALR_LINK: begin
        alu_src_a     = 2'b01;
        alu_src_b     = 2'b10;
        result_src    = 2'b10;
        reg_write_raw = 1'b1;
        retire        = 1'b1;
        state_nxt     = S_FETCH;
      end
      S_TRAP: begin
        halted = 1'b1;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  // The strobes must stay quiet while reset is low, even though the FETCH gate is driven by mem_ready
  assign ir_write  = ir_write_raw  & resetn;
  assign pc_update = pc_update_raw & resetn;
  assign branch    = branch_raw    & resetn;
  assign reg_write = reg_write_raw & resetn;
  assign mem_we    = mem_we_raw    & resetn;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm. It checks the control vector of each state against hand-written values.
// The second instance is built with illegal opcodes retiring as a NOP.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       resetn;
  logic [6:0] opcode;
  logic       mem_ready;

  logic [1:0]  alu_op, alu_src_a, alu_src_b, result_src;
  logic        adr_src, ir_write, pc_update, branch, reg_write, mem_we, halted;
  logic [31:0] instret;
  logic [1:0]  alu_op1, alu_src_a1, alu_src_b1, result_src1;
  logic        adr_src1, ir_write1, pc_update1, branch1, reg_write1, mem_we1, halted1;
  logic [31:0] instret1;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.INSTRET_WIDTH(32), .TRAP_ON_ILLEGAL(1'b1)) dut (
    .clk(clk), .resetn(resetn), .opcode(opcode), .mem_ready(mem_ready),
    .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .result_src(result_src), .adr_src(adr_src), .ir_write(ir_write),
    .pc_update(pc_update), .branch(branch), .reg_write(reg_write),
    .mem_we(mem_we), .halted(halted), .instret(instret)
  );

  multicycle_control_fsm #(.INSTRET_WIDTH(32), .TRAP_ON_ILLEGAL(1'b0)) dut_nop (
    .clk(clk), .resetn(resetn), .opcode(opcode), .mem_ready(mem_ready),
    .alu_op(alu_op1), .alu_src_a(alu_src_a1), .alu_src_b(alu_src_b1),
    .result_src(result_src1), .adr_src(adr_src1), .ir_write(ir_write1),
    .pc_update(pc_update1), .branch(branch1), .reg_write(reg_write1),
    .mem_we(mem_we1), .halted(halted1), .instret(instret1)
  );

  // {alu_op, a, b, result_src, adr_src, ir_write, pc_update, branch, reg_write, mem_we, halted}
  wire [14:0] ctl  = {alu_op, alu_src_a, alu_src_b, result_src, adr_src,
                      ir_write, pc_update, branch, reg_write, mem_we, halted};
  wire [14:0] ctl1 = {alu_op1, alu_src_a1, alu_src_b1, result_src1, adr_src1,
                      ir_write1, pc_update1, branch1, reg_write1, mem_we1, halted1};

  localparam logic [14:0] V_FETCH   = 15'b00_00_10_10_0_1_1_0_0_0_0;
  localparam logic [14:0] V_FSTALL  = 15'b00_00_10_10_0_0_0_0_0_0_0;
  localparam logic [14:0] V_DECODE  = 15'b00_01_01_00_0_0_0_0_0_0_0;
  localparam logic [14:0] V_MEMADR  = 15'b00_10_01_00_0_0_0_0_0_0_0;
  localparam logic [14:0] V_MEMREAD = 15'b00_00_00_00_1_0_0_0_0_0_0;
  localparam logic [14:0] V_MEMWB   = 15'b00_00_00_01_0_0_0_0_1_0_0;
  localparam logic [14:0] V_MEMWR   = 15'b00_00_00_00_1_0_0_0_0_1_0;
  localparam logic [14:0] V_EXEC_R  = 15'b10_10_00_00_0_0_0_0_0_0_0;
  localparam logic [14:0] V_EXEC_I  = 15'b10_10_01_00_0_0_0_0_0_0_0;
  localparam logic [14:0] V_AUIPC   = 15'b00_01_01_00_0_0_0_0_0_0_0;
  localparam logic [14:0] V_ALUWB   = 15'b00_00_00_00_0_0_0_0_1_0_0;
  localparam logic [14:0] V_BRANCH  = 15'b01_10_00_00_0_0_0_1_0_0_0;
  localparam logic [14:0] V_JAL     = 15'b00_01_10_00_0_0_1_0_0_0_0;
  localparam logic [14:0] V_JALR    = 15'b00_10_01_10_0_0_1_0_0_0_0;
  localparam logic [14:0] V_JLINK   = 15'b00_01_10_10_0_0_0_0_1_0_0;
  localparam logic [14:0] V_TRAP    = 15'b00_00_00_00_0_0_0_0_0_0_1;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_ret;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Apply inputs just after an edge, check mid-cycle, then advance one clock
  task automatic cyc(input string tag, input logic [6:0] op, input logic mr, input logic [14:0] exp);
    opcode    = op;
    mem_ready = mr;
    #1;
    chk(tag, {17'd0, ctl}, {17'd0, exp});
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn    = 1'b0;
    opcode    = 7'd0;
    mem_ready = 1'b1;
    exp_ret   = 32'd0;
    #12;
    chk("rst_ctl", {17'd0, ctl}, {17'd0, V_FSTALL});
    chk("rst_instret", instret, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;

    // R-type: 4 cycles
    cyc("r_fetch",  7'b0110011, 1'b1, V_FETCH);
    cyc("r_decode", 7'b0110011, 1'b1, V_DECODE);
    cyc("r_exec",   7'b0110011, 1'b1, V_EXEC_R);
    cyc("r_wb",     7'b0110011, 1'b1, V_ALUWB);
    exp_ret++;
    chk("r_instret", instret, exp_ret);

    // I-type and LUI share the execute vector; AUIPC uses old PC
    cyc("i_fetch",  7'b0010011, 1'b1, V_FETCH);
    cyc("i_decode", 7'b0010011, 1'b1, V_DECODE);
    cyc("i_exec",   7'b0010011, 1'b1, V_EXEC_I);
    cyc("i_wb",     7'b0010011, 1'b1, V_ALUWB);
    exp_ret++;
    cyc("lui_fetch",  7'b0110111, 1'b1, V_FETCH);
    cyc("lui_decode", 7'b0110111, 1'b1, V_DECODE);
    cyc("lui_exec",   7'b0110111, 1'b1, V_EXEC_I);
    cyc("lui_wb",     7'b0110111, 1'b1, V_ALUWB);
    exp_ret++;
    cyc("auipc_fetch",  7'b0010111, 1'b1, V_FETCH);
    cyc("auipc_decode", 7'b0010111, 1'b1, V_DECODE);
    cyc("auipc_exec",   7'b0010111, 1'b1, V_AUIPC);
    cyc("auipc_wb",     7'b0010111, 1'b1, V_ALUWB);
    exp_ret++;
    chk("i_instret", instret, exp_ret);

    // Load with 3 wait cycles: 8 cycles total
    cyc("ld_fetch",  7'b0000011, 1'b1, V_FETCH);
    cyc("ld_decode", 7'b0000011, 1'b1, V_DECODE);
    cyc("ld_adr",    7'b0000011, 1'b1, V_MEMADR);
    for (int i = 0; i < 3; i++) cyc("ld_wait", 7'b0000011, 1'b0, V_MEMREAD);
    cyc("ld_read",   7'b0000011, 1'b1, V_MEMREAD);
    chk("ld_not_yet", instret, exp_ret);
    cyc("ld_wb",     7'b0000011, 1'b1, V_MEMWB);
    exp_ret++;
    chk("ld_instret", instret, exp_ret);

    // Store with 2 wait cycles: mem_we held 3 cycles
    cyc("st_fetch",  7'b0100011, 1'b1, V_FETCH);
    cyc("st_decode", 7'b0100011, 1'b1, V_DECODE);
    cyc("st_adr",    7'b0100011, 1'b1, V_MEMADR);
    cyc("st_wait0",  7'b0100011, 1'b0, V_MEMWR);
    cyc("st_wait1",  7'b0100011, 1'b0, V_MEMWR);
    cyc("st_write",  7'b0100011, 1'b1, V_MEMWR);
    exp_ret++;
    chk("st_instret", instret, exp_ret);

    // Branch: 3 cycles
    cyc("br_fetch",  7'b1100011, 1'b1, V_FETCH);
    cyc("br_decode", 7'b1100011, 1'b1, V_DECODE);
    cyc("br_exec",   7'b1100011, 1'b1, V_BRANCH);
    exp_ret++;
    chk("br_instret", instret, exp_ret);

    // JAL then JALR
    cyc("jal_fetch",  7'b1101111, 1'b1, V_FETCH);
    cyc("jal_decode", 7'b1101111, 1'b1, V_DECODE);
    cyc("jal_exec",   7'b1101111, 1'b1, V_JAL);
    cyc("jal_link",   7'b1101111, 1'b1, V_ALUWB);
    exp_ret++;
    cyc("jalr_fetch",  7'b1100111, 1'b1, V_FETCH);
    cyc("jalr_decode", 7'b1100111, 1'b1, V_DECODE);
    cyc("jalr_exec",   7'b1100111, 1'b1, V_JALR);
    cyc("jalr_link",   7'b1100111, 1'b1, V_JLINK);
    exp_ret++;
    chk("jmp_instret", instret, exp_ret);

    // Fetch stall holds FETCH with no strobes
    cyc("fetch_stall0", 7'b0110011, 1'b0, V_FSTALL);
    cyc("fetch_stall1", 7'b0110011, 1'b0, V_FSTALL);
    chk("nop_side_instret", instret1, exp_ret);

    // Async reset mid-MEMREAD
    cyc("rl_fetch",  7'b0000011, 1'b1, V_FETCH);
    cyc("rl_decode", 7'b0000011, 1'b1, V_DECODE);
    cyc("rl_adr",    7'b0000011, 1'b1, V_MEMADR);
    cyc("rl_wait",   7'b0000011, 1'b0, V_MEMREAD);
    #2;
    mem_ready = 1'b1;
    resetn    = 1'b0;
    #1;
    chk("rl_async_ctl", {17'd0, ctl}, {17'd0, V_FSTALL});
    chk("rl_async_instret", instret, 32'd0);
    exp_ret = 32'd0;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    resetn    = 1'b1;
    cyc("rl_after0", 7'b0000011, 1'b0, V_FSTALL);
    cyc("rl_after1", 7'b0000011, 1'b0, V_FSTALL);
    chk("rl_instret_after", instret, 32'd0);

    // Illegal opcode: trap on one instance, NOP retire on the other
    cyc("ill_fetch",  7'b0000000, 1'b1, V_FETCH);
    cyc("ill_decode", 7'b0000000, 1'b0, V_DECODE);
    chk("nop_ctl", {17'd0, ctl1}, {17'd0, V_FSTALL});
    chk("nop_instret", instret1, 32'd1);
    for (int i = 0; i < 20; i++) cyc("trap_hold", 7'b0000000, 1'b0, V_TRAP);
    chk("trap_instret", instret, 32'd0);
    chk("nop_instret_hold", instret1, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
